// File: rtl/pipeline_exec_ctrl_pkg.sv
// rtl/pipeline_exec_ctrl_pkg.sv - shared types and command codes for the pipeline execution controller
package pipeline_exec_ctrl_pkg;

  localparam int NB_CMD_DEFAULT = 2;

  typedef logic [NB_CMD_DEFAULT-1:0] cmd_code_t;

  localparam cmd_code_t CMD_RESTART = 2'b00;
  localparam cmd_code_t CMD_RUN     = 2'b01;
  localparam cmd_code_t CMD_STEP    = 2'b10;
  localparam cmd_code_t CMD_STOP    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_HALTED,
    ST_CLEAR
  } state_e;

  // Commands are only sampled in the states that can act on them
  function automatic logic accepts_cmd(input state_e s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
  endfunction

  // The pipeline advances only while running or single-stepping
  function automatic logic pipe_running(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear wins over enable; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// rtl/pipeline_exec_ctrl.sv - run/step/halt controller gating the pipeline enable
module pipeline_exec_ctrl
  import pipeline_exec_ctrl_pkg::*;
#(
  parameter int NB_CYCLE = 32,
  parameter int NB_CMD   = NB_CMD_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [NB_CMD-1:0]   i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_WB_halt,
  output logic                o_pipe_enable,
  output logic                o_pipe_clear,
  output logic                o_done,
  output logic                o_cmd_err,
  output logic                o_halted,
  output logic [NB_CYCLE-1:0] o_cycle_count
);

  state_e    state;
  state_e    state_next;
  logic      done;
  logic      done_next;
  logic      cmd_err;
  logic      cmd_err_next;
  logic      xfer;
  cmd_code_t cmd;

  assign cmd  = cmd_code_t'(i_cmd);
  assign xfer = i_cmd_valid && o_cmd_ready;

  // Moore decodes straight from the registered state
  assign o_cmd_ready   = accepts_cmd(state);
  assign o_pipe_enable = pipe_running(state);
  assign o_pipe_clear  = (state == ST_CLEAR);
  assign o_halted      = (state == ST_HALTED);
  assign o_done        = done;
  assign o_cmd_err     = cmd_err;

  // State and pulse registers; reset overrides any command or halt in flight
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_next;
      done    <= done_next;
      cmd_err <= cmd_err_next;
    end
  end

  // Next-state and next-pulse decision; halt from WB beats any command in RUN
  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    cmd_err_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          case (cmd)
            CMD_RUN:     state_next = ST_RUN;
            CMD_STEP:    state_next = ST_STEP;
            CMD_RESTART: state_next = ST_CLEAR;
            default:     state_next = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        if (i_WB_halt) begin
          state_next = ST_HALTED;
          done_next  = 1'b1;
        end else if (xfer) begin
          case (cmd)
            CMD_STOP:    state_next = ST_IDLE;
            CMD_RESTART: state_next = ST_CLEAR;
            default:     cmd_err_next = 1'b1;
          endcase
        end
      end
      ST_STEP: begin
        done_next = 1'b1;
        if (i_WB_halt) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (xfer) begin
          if (cmd == CMD_RESTART) begin
            state_next = ST_CLEAR;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  sat_counter #(
    .WIDTH (NB_CYCLE)
  ) u_cycle_counter (
    .clk    (i_clk),
    .clear  (i_reset || o_pipe_clear),
    .enable (o_pipe_enable),
    .count  (o_cycle_count)
  );

endmodule

// File: doc/pipeline_exec_ctrl.md
PIPELINE_EXEC_CTRL -- requirements
Module: pipeline_exec_ctrl

Interface
REQ-001 SHALL have parameter NB_CYCLE, default 32, width of the executed-cycle counter.
REQ-002 SHALL have parameter NB_CMD, default 2, width of the command code.
REQ-003 SHALL have port i_clk, input, 1, rising-edge clock.
REQ-004 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_cmd_valid, input, 1, command strobe from the debug unit.
REQ-006 SHALL have port i_cmd, input, NB_CMD, command code: 00 RESTART, 01 RUN, 10 STEP, 11 STOP.
REQ-007 SHALL have port o_cmd_ready, output, 1, the block accepts a command this cycle.
REQ-008 SHALL have port i_WB_halt, input, 1, a HALT instruction is in the WB stage.
REQ-009 SHALL have port o_pipe_enable, output, 1, global enable for the PC and all pipeline registers.
REQ-010 SHALL have port o_pipe_clear, output, 1, one-cycle clear of the PC and pipeline registers.
REQ-011 SHALL have port o_done, output, 1, one-cycle pulse when a step completes or the program halts.
REQ-012 SHALL have port o_cmd_err, output, 1, one-cycle pulse when an accepted command is illegal in the current state.
REQ-013 SHALL have port o_halted, output, 1, high while in HALTED.
REQ-014 SHALL have port o_cycle_count, output, NB_CYCLE, number of enabled cycles since the last clear.

Function
REQ-015 SHALL implement a Moore FSM with states IDLE, RUN, STEP, HALTED, CLEAR; a command transfers when i_cmd_valid and o_cmd_ready are both high at a rising edge.
REQ-016 SHALL drive o_cmd_ready high in IDLE, RUN and HALTED, and low in STEP and CLEAR.
REQ-017 SHALL drive o_pipe_enable high only in RUN and STEP; it SHALL first be high in the cycle after the command transfers.
REQ-018 IDLE: RUN goes to RUN; STEP goes to STEP; RESTART goes to CLEAR; STOP is a legal no-op.
REQ-019 RUN: STOP goes to IDLE, so enable is low from the next cycle; RUN and STEP pulse o_cmd_err and cause no change; RESTART goes to CLEAR.
REQ-020 STEP: lasts exactly one enabled cycle, then goes to IDLE with o_done high in the first IDLE cycle.
REQ-021 In RUN or STEP, i_WB_halt high at a rising edge SHALL move the FSM to HALTED and pulse o_done in the first HALTED cycle; i_WB_halt SHALL be ignored while o_pipe_enable is low.
REQ-022 If i_WB_halt and a transferring command coincide in RUN, halt SHALL take priority and the command SHALL be consumed without o_cmd_err.
REQ-023 HALTED: o_pipe_enable is 0 and o_halted is 1; only RESTART is legal and goes to CLEAR; RUN, STEP and STOP pulse o_cmd_err.
REQ-024 CLEAR: o_pipe_clear is high for exactly one cycle, o_cycle_count loads 0 at the end of that cycle, and the FSM goes to IDLE.
REQ-025 o_cycle_count SHALL increment by 1 at each edge where o_pipe_enable is high, and SHALL saturate at 2^NB_CYCLE-1 without wrapping.
REQ-026 o_done and o_cmd_err SHALL be registered, SHALL be single-cycle pulses, and SHALL never be high in the same cycle.

Reset
REQ-027 While i_reset is high at an edge, the block SHALL enter IDLE with every output 0 except o_cmd_ready, and o_cycle_count SHALL be 0.
REQ-028 Reset asserted during RUN or STEP SHALL deassert o_pipe_enable in the cycle after the edge and SHALL NOT produce o_done.
REQ-029 Reset SHALL override any concurrent command or i_WB_halt.

Structure
REQ-030 A shared package SHALL hold the state encoding typedef, the command code constants (CMD_RESTART, CMD_RUN, CMD_STEP, CMD_STOP) and the NB_CMD default.
REQ-031 The cycle counter SHALL be a sub-module sat_counter, with parameter width, clear and enable inputs, and saturating behaviour.
REQ-032 The FSM SHALL use one registered state plus registered pulse outputs; o_pipe_enable, o_pipe_clear, o_halted and o_cmd_ready SHALL be decoded from state.

Verification
REQ-033 Scenario 1, step: from reset, issue STEP three times, 5 cycles apart -> enable high for exactly 3 single cycles, o_cycle_count=3, three o_done pulses, o_cmd_ready low in each STEP cycle.
REQ-034 Scenario 2, run to halt: issue RUN, assert i_WB_halt on the 10th enabled cycle -> HALTED, o_cycle_count=10, one o_done pulse, enable low afterwards.
REQ-035 Scenario 3, illegal commands: in HALTED issue RUN then STEP -> two o_cmd_err pulses, state unchanged; then RESTART -> o_pipe_clear one cycle, count=0, IDLE.
REQ-036 Scenario 4, collision and stop: in RUN, STOP in the same cycle as i_WB_halt -> HALTED with no o_cmd_err; separately, RUN then STOP after 4 cycles -> IDLE, count=4.
REQ-037 Scenario 5, saturation: NB_CYCLE=4, RUN for 20 cycles -> count holds at 15.
REQ-038 Scenario 6, reset mid-run: assert reset during RUN -> enable 0 next cycle, count 0, no o_done.
